// File: rtl/mac_pkg.sv
// Shared definitions for the 32-lane MAC array and its bit-serial accumulator.
package mac_pkg;

    localparam int unsigned MAC_LANES  = 32;
    localparam int unsigned MAC_W      = 8;
    localparam int unsigned WEIGHT_MAX = 7;
    localparam int unsigned MAC_MAX    = MAC_LANES * WEIGHT_MAX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

    // One guard bit beyond the shifted plane sums covers the signed range.
    function automatic int unsigned acc_width(input int unsigned mac_w, input int unsigned act_bits);
        return mac_w + act_bits + 1;
    endfunction

endpackage

// File: rtl/mac_bitserial_accum.sv
// Shift-and-add combiner of MSB-first activation bit-plane sums into a signed dot
// product, presented to the next stage under a valid/ready handshake.
module mac_bitserial_accum #(
    parameter int unsigned MAC_W      = mac_pkg::MAC_W,
    parameter int unsigned ACT_BITS   = 4,
    parameter bit          SIGNED_ACT = 1'b0,
    parameter int unsigned ACC_W      = mac_pkg::acc_width(MAC_W, ACT_BITS)
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        mac_valid,
    input  logic [MAC_W-1:0]            mac_in,
    output logic [$clog2(ACT_BITS)-1:0] plane_sel,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_W-1:0]            result,
    output logic                        drop_err
);
    import mac_pkg::*;

    localparam int unsigned     SEL_W    = $clog2(ACT_BITS);
    localparam logic [SEL_W-1:0] TOP_SEL = SEL_W'(ACT_BITS - 1);

    if (ACT_BITS < 2) begin : g_bad_act_bits
        $error("ACT_BITS must be at least 2");
    end

    acc_state_t       state_q;
    logic [ACC_W-1:0] acc_q;
    logic [SEL_W-1:0] cnt_q;
    logic [SEL_W-1:0] plane_sel_q;
    logic [ACC_W-1:0] result_q;
    logic             out_valid_q;
    logic             drop_err_q;

    logic [ACC_W-1:0] mac_ext;
    logic [ACC_W-1:0] term;
    logic [ACC_W-1:0] sum_d;
    logic             last_plane;

    // The MSB plane of a signed activation carries negative weight.
    always_comb begin
        mac_ext    = ACC_W'(mac_in);
        term       = (SIGNED_ACT && (cnt_q == '0)) ? (~mac_ext + ACC_W'(1)) : mac_ext;
        sum_d      = (acc_q << 1) + term;
        last_plane = (cnt_q == TOP_SEL);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            plane_sel_q <= TOP_SEL;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            if (mac_valid && (state_q != ACCUM)) begin
                drop_err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= ACCUM;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        plane_sel_q <= TOP_SEL;
                        drop_err_q  <= 1'b0;
                    end
                end
                ACCUM: begin
                    // A start here aborts: the partial sum is discarded.
                    if (start) begin
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        plane_sel_q <= TOP_SEL;
                    end else if (mac_valid) begin
                        if (last_plane) begin
                            result_q    <= sum_d;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                            acc_q       <= '0;
                            cnt_q       <= '0;
                            plane_sel_q <= TOP_SEL;
                        end else begin
                            acc_q       <= sum_d;
                            cnt_q       <= cnt_q + SEL_W'(1);
                            plane_sel_q <= plane_sel_q - SEL_W'(1);
                        end
                    end
                end
                DONE: begin
                    // Start is honoured only together with acceptance, never overwriting the result.
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        if (start) begin
                            state_q     <= ACCUM;
                            acc_q       <= '0;
                            cnt_q       <= '0;
                            plane_sel_q <= TOP_SEL;
                            drop_err_q  <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign plane_sel = plane_sel_q;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign drop_err  = drop_err_q;

endmodule
